// File: rtl/memory_stage.sv
// Y86-64 pipeline memory stage: M pipeline register, byte-addressable data
// memory (load/store for the instruction in M) and W pipeline register.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   e_*                  - execute-stage results loaded into M
//   M_bubble, W_stall    - pipeline control (M bubble injection, W hold)
//   M_*                  - M register fields (forwarding / control)
//   m_stat, m_valM       - combinational status and load data of M instruction
//   W_*                  - W register fields feeding write-back
module memory_stage #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    input  logic        M_bubble,
    input  logic        W_stall,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    // Highest legal start address of an 8-byte access.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    logic [2:0]  M_stat;
    logic [7:0]  mem [MEM_BYTES] = '{default: 8'h00};

    logic        mem_access;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic        dmem_error;
    logic        wr_en;
    logic [63:0] rd_data;

    // M pipeline register
    always_ff @(posedge clk) begin
        if (reset || M_bubble) begin
            M_stat  <= SAOK;
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= 64'd0;
            M_valA  <= 64'd0;
            M_dstE  <= R_NONE;
            M_dstM  <= R_NONE;
        end else begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= e_dstM;
        end
    end

    // Access decode and address selection
    always_comb begin
        mem_access = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 64'd0;
        case (M_icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin
                mem_access = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = M_valE;
            end
            I_MRMOVQ: begin
                mem_access = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = M_valE;
            end
            I_POPQ, I_RET: begin
                mem_access = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = M_valA;
            end
            default: ;
        endcase
    end

    // Full 64-bit unsigned bound check so huge addresses cannot alias into range
    assign dmem_error = mem_access && (mem_addr > LAST_ADDR);

    // Stores are dropped once anything older or this instruction has faulted,
    // and when reset arrives while the store sits in M.
    assign wr_en = mem_write && !dmem_error && (M_stat == SAOK) &&
                   (W_stat == SAOK) && !reset;

    // Little-endian 8-byte read
    always_comb begin
        rd_data = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rd_data[8*i +: 8] = mem[AW'(mem_addr + 64'(i))];
        end
    end

    assign m_valM = (mem_read && !dmem_error) ? rd_data : 64'd0;
    assign m_stat = dmem_error ? SADR : M_stat;

    // Little-endian 8-byte write; contents are not touched by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem[AW'(mem_addr + 64'(i))] <= M_valA[8*i +: 8];
            end
        end
    end

    // W pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            W_stat  <= SAOK;
            W_icode <= I_NOP;
            W_valE  <= 64'd0;
            W_valM  <= 64'd0;
            W_dstE  <= R_NONE;
            W_dstM  <= R_NONE;
        end else if (!W_stall) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
